// File: rtl/composite_luma_encoder.sv
// Composite video sample encoder: sync tip, blanking, optional colour burst and luma in a 3-stage clk_en pipeline.
// Optional colour burst generation is built only when COMPOSITE_COLORBURST_EN is defined.
module composite_luma_encoder #(
    parameter logic [7:0]  SYNC_LEVEL  = 8'd0,
    parameter logic [7:0]  BLANK_LEVEL = 8'd72,
    parameter logic [7:0]  BLACK_LEVEL = 8'd80,
    parameter logic [7:0]  WHITE_LEVEL = 8'd200,
    parameter int          BURST_DELAY = 4,
    parameter int          BURST_LEN   = 10,
    parameter logic [7:0]  BURST_AMP   = 8'd20,
    parameter logic [31:0] PHASE_INC   = 32'h2AAA_AAAB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        de,
    input  logic [23:0] rgb,
    output logic [7:0]  dac,
    output logic        sync_out,
    output logic        burst_active
);

    localparam logic [7:0] LUMA_SPAN = WHITE_LEVEL - BLACK_LEVEL;

    // ------------------------------------------------------------------
    // Stage 1: input capture
    // ------------------------------------------------------------------
    logic        s1_hsync;
    logic        s1_vsync;
    logic        s1_hblank;
    logic        s1_vblank;
    logic        s1_de;
    logic [23:0] s1_rgb;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hsync  <= 1'b0;
            s1_vsync  <= 1'b0;
            s1_hblank <= 1'b0;
            s1_vblank <= 1'b0;
            s1_de     <= 1'b0;
            s1_rgb    <= '0;
        end else if (clk_en) begin
            s1_hsync  <= hsync;
            s1_vsync  <= vsync;
            s1_hblank <= hblank;
            s1_vblank <= vblank;
            s1_de     <= de;
            s1_rgb    <= rgb;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: luma and timing flags
    // ------------------------------------------------------------------
    logic [15:0] y_sum;
    logic [7:0]  s2_y;
    logic        s2_sync;
    logic        s2_hblank;
    logic        s2_vblank;
    logic        s2_de;

    // Coefficients sum to 256, so the 16-bit sum cannot overflow.
    assign y_sum = ({8'd0, s1_rgb[23:16]} * 16'd77)
                 + ({8'd0, s1_rgb[15:8]}  * 16'd150)
                 + ({8'd0, s1_rgb[7:0]}   * 16'd29);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_y      <= '0;
            s2_sync   <= 1'b0;
            s2_hblank <= 1'b0;
            s2_vblank <= 1'b0;
            s2_de     <= 1'b0;
        end else if (clk_en) begin
            s2_y      <= 8'(y_sum >> 8);
            s2_sync   <= s1_hsync | s1_vsync;
            s2_hblank <= s1_hblank;
            s2_vblank <= s1_vblank;
            s2_de     <= s1_de;
        end
    end

    // ------------------------------------------------------------------
    // Burst window generation (stage-2 aligned)
    // ------------------------------------------------------------------
    logic       burst_win;
    logic [7:0] burst_sample;

`ifdef COMPOSITE_COLORBURST_EN
    localparam int CNT_MAX = (BURST_DELAY > BURST_LEN) ? BURST_DELAY : BURST_LEN;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'((BURST_DELAY > 0) ? BURST_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] LEN_LOAD   = CNT_W'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
    localparam logic [7:0]       BURST_HI   = BLANK_LEVEL + BURST_AMP;
    localparam logic [7:0]       BURST_LO   = BLANK_LEVEL - BURST_AMP;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_BURST
    } burst_state_t;

    burst_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic           s1_hsync_prev;
    logic           h_fall;
    logic           h_rise;
    logic           abort;
    logic [31:0]    phase;

    assign h_fall = s1_hsync_prev & ~s1_hsync;
    assign h_rise = s1_hsync & ~s1_hsync_prev;
    assign abort  = h_rise | s1_vsync | s1_de;

    // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (h_fall && !s1_vsync) begin
                    state_nxt = (BURST_DELAY == 0) ? ST_BURST : ST_DELAY;
                    cnt_nxt   = (BURST_DELAY == 0) ? LEN_LOAD : DELAY_LOAD;
                end
            end
            ST_DELAY, ST_BURST: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (h_fall) begin
                    // vsync is known low here, so a fresh edge re-arms the delay.
                    state_nxt = (BURST_DELAY == 0) ? ST_BURST : ST_DELAY;
                    cnt_nxt   = (BURST_DELAY == 0) ? LEN_LOAD : DELAY_LOAD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (state == ST_DELAY) begin
                    state_nxt = ST_BURST;
                    cnt_nxt   = LEN_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            s1_hsync_prev <= 1'b0;
        end else if (clk_en) begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            s1_hsync_prev <= s1_hsync;
        end
    end

    // Subcarrier accumulator runs on every clk, independent of the pixel enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else begin
            phase <= phase + PHASE_INC;
        end
    end

    assign burst_win    = (state == ST_BURST);
    assign burst_sample = phase[31] ? BURST_LO : BURST_HI;
`else
    logic unused_cfg;

    assign burst_win    = 1'b0;
    assign burst_sample = BLANK_LEVEL;
    assign unused_cfg   = ^{BURST_AMP, PHASE_INC, 32'(BURST_DELAY), 32'(BURST_LEN)};
`endif

    // ------------------------------------------------------------------
    // Stage 3: level select and output registers
    // ------------------------------------------------------------------
    logic [15:0] luma_prod;
    logic [8:0]  luma_sum;
    logic [7:0]  luma_code;
    logic [7:0]  dac_nxt;

    assign luma_prod = {8'd0, s2_y} * {8'd0, LUMA_SPAN};
    assign luma_sum  = {1'b0, BLACK_LEVEL} + {1'b0, 8'(luma_prod >> 8)};
    assign luma_code = luma_sum[8] ? 8'hFF : luma_sum[7:0];

    always_comb begin
        dac_nxt = luma_code;
        if (s2_sync) begin
            dac_nxt = SYNC_LEVEL;
        end else if (burst_win) begin
            dac_nxt = burst_sample;
        end else if (!s2_de || s2_hblank || s2_vblank) begin
            dac_nxt = BLANK_LEVEL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac          <= BLANK_LEVEL;
            sync_out     <= 1'b0;
            burst_active <= 1'b0;
        end else if (clk_en) begin
            dac          <= dac_nxt;
            sync_out     <= s2_sync;
            burst_active <= burst_win;
        end
    end

endmodule

// File: tb/tb_composite_luma_encoder.sv
// Directed bench for composite_luma_encoder: vector table plus hand-written reset, gating and burst sequences.
// Burst expectations follow COMPOSITE_COLORBURST_EN as seen by this compile.
module tb_composite_luma_encoder;

`ifdef COMPOSITE_COLORBURST_EN
    localparam bit BURST_BUILT = 1'b1;
`else
    localparam bit BURST_BUILT = 1'b0;
`endif

    localparam logic [7:0] BLANK = 8'd72;
    localparam logic [7:0] B_HI  = 8'd92;
    localparam logic [7:0] B_LO  = 8'd52;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        de;
        logic [23:0] rgb;
        logic [7:0]  exp_dac;
        logic        exp_sync;
        logic        exp_ba;
        logic        burst;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        hsync;
    logic        vsync;
    logic        hblank;
    logic        vblank;
    logic        de;
    logic [23:0] rgb;
    logic [7:0]  dac;
    logic        sync_out;
    logic        burst_active;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    composite_luma_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .hsync        (hsync),
        .vsync        (vsync),
        .hblank       (hblank),
        .vblank       (vblank),
        .de           (de),
        .rgb          (rgb),
        .dac          (dac),
        .sync_out     (sync_out),
        .burst_active (burst_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic hs, input logic vs, input logic hb, input logic vb,
                                input logic d, input logic [23:0] c, input logic [7:0] ed,
                                input logic es, input logic eb, input logic bu);
        vec_t v;
        v.hs = hs; v.vs = vs; v.hb = hb; v.vb = vb; v.de = d; v.rgb = c;
        v.exp_dac = ed; v.exp_sync = es; v.exp_ba = eb; v.burst = bu;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hsync = v.hs; vsync = v.vs; hblank = v.hb; vblank = v.vb; de = v.de; rgb = v.rgb;
    endtask

    task automatic tick(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    // Apply the queued vectors with clk_en every cycle; sample k emerges after its third tick.
    task automatic run_vecs(input string tag);
        vec_t idle;
        vec_t v;
        int   n;
        idle = mk(0, 0, 1, 0, 0, 24'h0, BLANK, 0, 0, 0);
        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            drive((i < n) ? vecs[i] : idle);
            tick(1'b1);
            if (i >= 2) begin
                v = vecs[i-2];
                if (v.burst) begin
                    n_vec++;
                    if (!(dac == B_HI || dac == B_LO)) begin
                        n_miss++;
                        $display("FAIL %s[%0d] burst dac: got %0d, expected %0d or %0d",
                                 tag, i - 2, dac, B_LO, B_HI);
                    end
                end else begin
                    check($sformatf("%s[%0d] dac", tag, i - 2), dac, v.exp_dac);
                end
                check($sformatf("%s[%0d] sync_out", tag, i - 2), {7'd0, sync_out}, {7'd0, v.exp_sync});
                check($sformatf("%s[%0d] burst_active", tag, i - 2), {7'd0, burst_active}, {7'd0, v.exp_ba});
            end
        end
        vecs.delete();
    endtask

    // Hsync pulse followed by blanking; returns with the falling-edge sample next in line.
    task automatic push_hsync_pulse();
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 1, 0, 0, 24'h0, 8'd0, 1, 0, 0));
    endtask

    task automatic push_window_sample(input int j);
        if (j >= 4 && j < 14 && BURST_BUILT)
            vecs.push_back(mk(0, 0, 1, 0, 0, 24'h0, BLANK, 0, 1, 1));
        else
            vecs.push_back(mk(0, 0, 1, 0, 0, 24'h0, BLANK, 0, 0, 0));
    endtask

    logic [23:0] gate_rgb [5];
    logic [7:0]  gate_exp [5];

    initial begin
        reset = 1'b1; clk_en = 1'b0;
        hsync = 0; vsync = 0; hblank = 0; vblank = 0; de = 0; rgb = '0;

        // Reset state, held across a clock edge with enable high.
        clk_en = 1'b1;
        #12;
        check("reset dac", dac, BLANK);
        check("reset sync_out", {7'd0, sync_out}, 8'd0);
        check("reset burst_active", {7'd0, burst_active}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Main table: luma levels, blanking and sync priority.
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'hFFFFFF, 8'd199, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'hFF0000, 8'd115, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'h000000, 8'd80,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'h00FF00, 8'd149, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'h0000FF, 8'd93,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'h808080, 8'd140, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 24'hFFFFFF, BLANK,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 24'hFFFFFF, BLANK,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 24'hFFFFFF, BLANK,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 24'hFFFFFF, 8'd0,   1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 24'h000000, 8'd0,   1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 24'h000000, 8'd0,   1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 24'h000000, 8'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 24'h000000, BLANK,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 24'h404040, 8'd110, 0, 0, 0));
        run_vecs("table");

        // clk_en one cycle in four; rgb scribbled while disabled.
        gate_rgb[0] = 24'hFFFFFF; gate_exp[0] = 8'd199;
        gate_rgb[1] = 24'hFF0000; gate_exp[1] = 8'd115;
        gate_rgb[2] = 24'h000000; gate_exp[2] = 8'd80;
        gate_rgb[3] = 24'h00FF00; gate_exp[3] = 8'd149;
        gate_rgb[4] = 24'h0000FF; gate_exp[4] = 8'd93;
        for (int k = 0; k < 7; k++) begin
            logic [7:0] want;
            want = (k >= 2) ? gate_exp[k-2] : BLANK;
            hsync = 0; vsync = 0; vblank = 0;
            de     = (k < 5);
            hblank = (k >= 5);
            rgb    = (k < 5) ? gate_rgb[k] : 24'h0;
            tick(1'b1);
            check($sformatf("gate tick%0d dac", k), dac, want);
            for (int h = 0; h < 3; h++) begin
                rgb = 24'($urandom);
                tick(1'b0);
                check($sformatf("gate hold%0d.%0d dac", k, h), dac, want);
            end
        end

        // Burst after an hsync falling edge with vsync low.
        push_hsync_pulse();
        for (int j = 0; j < 18; j++) push_window_sample(j);
        run_vecs("burst");

        // Same edge with vsync high on the falling-edge sample: no burst.
        push_hsync_pulse();
        vecs.push_back(mk(0, 1, 1, 0, 0, 24'h0, 8'd0, 1, 0, 0));
        for (int j = 1; j < 18; j++) vecs.push_back(mk(0, 0, 1, 0, 0, 24'h0, BLANK, 0, 0, 0));
        run_vecs("noburst");

        // de asserts three ticks into the burst window and aborts it.
        push_hsync_pulse();
        for (int j = 0; j < 7; j++) push_window_sample(j);
        for (int j = 7; j < 16; j++) vecs.push_back(mk(0, 0, 0, 0, 1, 24'hFFFFFF, 8'd199, 0, 0, 0));
        run_vecs("abort");

        // Mid-line asynchronous reset with clk_en toggling.
        hsync = 0; vsync = 0; hblank = 0; vblank = 0; de = 1; rgb = 24'hFFFFFF;
        for (int c = 0; c < 8; c++) tick(c[0]);
        check("preres dac", dac, 8'd199);
        #2 reset = 1'b1;
        #1;
        check("midres dac", dac, BLANK);
        check("midres sync_out", {7'd0, sync_out}, 8'd0);
        check("midres burst_active", {7'd0, burst_active}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1'b1);
        check("post-reset tick1 dac", dac, BLANK);
        tick(1'b1);
        check("post-reset tick2 dac", dac, BLANK);
        tick(1'b1);
        check("post-reset tick3 dac", dac, 8'd199);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
